// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches to instruction memory, buffers
// returned words with their PCs, and flushes/discards stale responses on redirect.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic        o_im_req,
    output logic [31:0] o_im_addr,
    input  logic        i_im_gnt,
    input  logic        i_im_rvalid,
    input  logic [31:0] i_im_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int          CW        = $clog2(DEPTH + 1);
    localparam int          PW        = $clog2(DEPTH);
    localparam logic [CW:0] FULL_FILL = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_disc;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic          w_issue;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_fill;
    logic [31:0]   w_redirect_pc;

    // A request is only offered when a FIFO slot is guaranteed for its response.
    assign w_fill        = {1'b0, r_occ} + {1'b0, r_outst};
    assign o_im_req      = i_rstn & (w_fill < FULL_FILL) & ~i_redirect;
    assign o_im_addr     = r_fetch_pc;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

    assign w_issue = o_im_req & i_im_gnt;
    assign w_resp  = i_im_rvalid & (r_outst != '0);
    assign w_push  = w_resp & (r_disc == '0) & ~i_redirect;
    assign w_pop   = o_inst_valid & i_inst_ready;

    assign o_inst_valid = (r_occ != '0);
    assign o_inst       = o_inst_valid ? r_mem_inst[r_rptr] : NOP;
    assign o_inst_pc    = o_inst_valid ? r_mem_pc[r_rptr]   : 32'h0;

    // Responses already in flight at a redirect still return and must be discarded.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_occ      <= '0;
            r_outst    <= '0;
            r_disc     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_occ      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_outst    <= r_outst - CW'(w_resp);
            r_disc     <= r_outst - CW'(w_resp);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wptr    <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_occ   <= r_occ + CW'(w_push) - CW'(w_pop);
            r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
            if (w_resp && (r_disc != '0)) begin
                r_disc <= r_disc - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= i_im_rdata;
            r_mem_pc[r_wptr]   <= r_resp_pc;
        end
    end

    a_credit : assert property (@(posedge i_clk) disable iff (!i_rstn) w_fill <= FULL_FILL);
    a_disc   : assert property (@(posedge i_clk) disable iff (!i_rstn) r_disc <= r_outst);
    a_nofull : assert property (@(posedge i_clk) disable iff (!i_rstn)
                                !(w_push && (r_occ == CW'(DEPTH))));
    a_proto  : assert property (@(posedge i_clk) disable iff (!i_rstn)
                                !(i_im_rvalid && (r_outst == '0)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: an in-order IM responder model with programmable
// latency feeds the queue while each task checks fetch addresses and delivered words.
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imReq;
    logic [31:0] imAddr;
    logic        imGnt = 1'b1;
    logic        imRvalid = 1'b0;
    logic [31:0] imRdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instReady = 1'b1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    int          cyc = 0;
    int          rspLat = 1;
    bit          rspManual = 1'b0;
    logic        manRvalid = 1'b0;
    logic [31:0] manRdata = 32'h0;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .o_im_req     (imReq),
        .o_im_addr    (imAddr),
        .i_im_gnt     (imGnt),
        .i_im_rvalid  (imRvalid),
        .i_im_rdata   (imRdata),
        .i_redirect   (redirect),
        .i_redirect_pc(redirectPc),
        .o_inst_valid (instValid),
        .o_inst       (inst),
        .o_inst_pc    (instPc),
        .i_inst_ready (instReady)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Issues are recorded mid-cycle, when request, grant and redirect are all settled.
    always @(negedge clk) begin
        if (!rstn) begin
            pending.delete();
        end else if (imReq && imGnt) begin
            pending.push_back('{addr: imAddr, due: cyc + rspLat});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rspManual) begin
            imRvalid = manRvalid;
            imRdata  = manRdata;
        end else if (rstn && (pending.size() > 0) && (pending[0].due <= cyc)) begin
            imRvalid = 1'b1;
            imRdata  = memWord(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imRvalid = 1'b0;
            imRdata  = 32'h0;
        end
    end

    task automatic toMid();
        @(negedge clk);
    endtask

    task automatic toNext();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn       = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        imGnt      = 1'b1;
        instReady  = 1'b1;
        rspLat     = 1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        toMid();
        checks++;
        if (imReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_req got=%h exp=0", imReq);
        end
        checks++;
        if (imAddr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%h exp=0", imAddr);
        end
        checks++;
        if ({instValid, instPc, inst} !== {1'b0, 32'h0, NOP}) begin
            failures++;
            $display("[TB] FAIL reset_out got=%h exp=%h", {instValid, instPc, inst}, {1'b0, 32'h0, NOP});
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        doReset();
        for (int k = 0; k < 8; k++) begin
            toMid();
            checks++;
            if ({imReq, imAddr} !== {1'b1, 32'(4 * k)}) begin
                failures++;
                $display("[TB] FAIL stream_req c%0d got=%h exp=%h", k, {imReq, imAddr}, {1'b1, 32'(4 * k)});
            end
            pc = 32'(4 * (k - 2));
            checks++;
            if (k < 2) begin
                if (instValid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_early c%0d got=%h exp=0", k, instValid);
                end
            end else if ({instValid, instPc, inst} !== {1'b1, pc, memWord(pc)}) begin
                failures++;
                $display("[TB] FAIL stream_out c%0d got=%h exp=%h", k, {instValid, instPc, inst}, {1'b1, pc, memWord(pc)});
            end
            toNext();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc;
        doReset();
        instReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            toMid();
            checks++;
            if (k < 4) begin
                if ({imReq, imAddr} !== {1'b1, 32'(4 * k)}) begin
                    failures++;
                    $display("[TB] FAIL bp_issue c%0d got=%h exp=%h", k, {imReq, imAddr}, {1'b1, 32'(4 * k)});
                end
            end else if (imReq !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_full c%0d got=%h exp=0", k, imReq);
            end
            toNext();
        end
        instReady = 1'b1;
        for (int k = 6; k < 10; k++) begin
            toMid();
            pc = 32'(4 * (k - 6));
            checks++;
            if ({instValid, instPc, inst} !== {1'b1, pc, memWord(pc)}) begin
                failures++;
                $display("[TB] FAIL bp_pop c%0d got=%h exp=%h", k, {instValid, instPc, inst}, {1'b1, pc, memWord(pc)});
            end
            if (k == 6) begin
                checks++;
                if (imReq !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bp_req_hold got=%h exp=0", imReq);
                end
            end
            if (k == 7) begin
                checks++;
                if ({imReq, imAddr} !== {1'b1, 32'h10}) begin
                    failures++;
                    $display("[TB] FAIL bp_req_resume got=%h exp=%h", {imReq, imAddr}, {1'b1, 32'h10});
                end
            end
            toNext();
        end
    endtask

    task automatic test_redirect_drain();
        doReset();
        rspLat = 4;
        repeat (3) toNext();
        redirect   = 1'b1;
        redirectPc = 32'h100;
        toMid();
        checks++;
        if (imReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_req_redirect got=%h exp=0", imReq);
        end
        toNext();
        redirect = 1'b0;
        toMid();
        checks++;
        if ({imReq, imAddr} !== {1'b1, 32'h100}) begin
            failures++;
            $display("[TB] FAIL drain_newaddr got=%h exp=%h", {imReq, imAddr}, {1'b1, 32'h100});
        end
        for (int k = 4; k < 9; k++) begin
            if (k > 4) toMid();
            checks++;
            if (instValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_stale c%0d got=%h exp=0", k, instValid);
            end
            toNext();
        end
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h100, memWord(32'h100)}) begin
            failures++;
            $display("[TB] FAIL drain_first got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h100, memWord(32'h100)});
        end
        toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h104, memWord(32'h104)}) begin
            failures++;
            $display("[TB] FAIL drain_second got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h104, memWord(32'h104)});
        end
        toNext();
    endtask

    task automatic test_redirect_coincident();
        doReset();
        repeat (2) toNext();
        redirect   = 1'b1;
        redirectPc = 32'h200;
        toMid();
        checks++;
        if ({imReq, instValid, instPc, imRvalid} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL coin_cycle got=%h exp=%h", {imReq, instValid, instPc, imRvalid}, {1'b0, 1'b1, 32'h0, 1'b1});
        end
        toNext();
        redirect = 1'b0;
        toMid();
        checks++;
        if ({instValid, imReq, imAddr} !== {1'b0, 1'b1, 32'h200}) begin
            failures++;
            $display("[TB] FAIL coin_flushed got=%h exp=%h", {instValid, imReq, imAddr}, {1'b0, 1'b1, 32'h200});
        end
        toNext();
        toMid();
        checks++;
        if (instValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coin_gap got=%h exp=0", instValid);
        end
        toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h200, memWord(32'h200)}) begin
            failures++;
            $display("[TB] FAIL coin_first got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h200, memWord(32'h200)});
        end
        toNext();
    endtask

    task automatic test_misaligned_wrap();
        doReset();
        redirect   = 1'b1;
        redirectPc = 32'h103;
        toNext();
        redirect = 1'b0;
        toMid();
        checks++;
        if ({imReq, imAddr} !== {1'b1, 32'h100}) begin
            failures++;
            $display("[TB] FAIL mis_addr got=%h exp=%h", {imReq, imAddr}, {1'b1, 32'h100});
        end
        repeat (2) toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h100, memWord(32'h100)}) begin
            failures++;
            $display("[TB] FAIL mis_pc got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h100, memWord(32'h100)});
        end
        toNext();
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        toNext();
        redirect = 1'b0;
        toMid();
        checks++;
        if ({imReq, imAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("[TB] FAIL wrap_top got=%h exp=%h", {imReq, imAddr}, {1'b1, 32'hFFFF_FFFC});
        end
        toNext();
        toMid();
        checks++;
        if ({imReq, imAddr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL wrap_zero got=%h exp=%h", {imReq, imAddr}, {1'b1, 32'h0});
        end
        toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'hFFFF_FFFC, memWord(32'hFFFF_FFFC)}) begin
            failures++;
            $display("[TB] FAIL wrap_out_top got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'hFFFF_FFFC, memWord(32'hFFFF_FFFC)});
        end
        toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h0, memWord(32'h0)}) begin
            failures++;
            $display("[TB] FAIL wrap_out_zero got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h0, memWord(32'h0)});
        end
        toNext();
    endtask

    task automatic test_reset_midstream();
        doReset();
        rspLat    = 2;
        instReady = 1'b0;
        repeat (4) toNext();
        toMid();
        checks++;
        if ({imReq, instValid, instPc} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL mid_before got=%h exp=%h", {imReq, instValid, instPc}, {1'b0, 1'b1, 32'h0});
        end
        toNext();
        rstn      = 1'b0;
        rspManual = 1'b1;
        manRvalid = 1'b1;
        manRdata  = 32'hBAD0_0000;
        #1;
        checks++;
        if ({imReq, imAddr, instValid, instPc, inst} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP}) begin
            failures++;
            $display("[TB] FAIL mid_reset got=%h exp=%h", {imReq, imAddr, instValid, instPc, inst}, {1'b0, 32'h0, 1'b0, 32'h0, NOP});
        end
        toNext();
        toNext();
        manRvalid = 1'b0;
        toNext();
        rspManual = 1'b0;
        instReady = 1'b1;
        rspLat    = 1;
        rstn      = 1'b1;
        toMid();
        checks++;
        if ({imReq, imAddr, instValid} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL mid_restart got=%h exp=%h", {imReq, imAddr, instValid}, {1'b1, 32'h0, 1'b0});
        end
        toNext();
        toMid();
        checks++;
        if (instValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_gap got=%h exp=0", instValid);
        end
        toNext();
        toMid();
        checks++;
        if ({instValid, instPc, inst} !== {1'b1, 32'h0, memWord(32'h0)}) begin
            failures++;
            $display("[TB] FAIL mid_first got=%h exp=%h", {instValid, instPc, inst}, {1'b1, 32'h0, memWord(32'h0)});
        end
        toNext();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_drain();
        test_redirect_coincident();
        test_misaligned_wrap();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
